// File: rtl/seq_control_unit_if.sv
// ---------------------------------------------------------------------------
// seq_control_unit_if
// Bundles the instruction-memory handshake and the decoded datapath controls
// that connect the sequencer to instruction memory and the ALU/RegFile.
//
// Signals:
//   instr        instruction word {opcode, ra1, ra2, wa}, MSB first
//   instr_valid  instr is valid for the current pc
//   pc           program counter presented to instruction memory
//   opcode       ALU opcode decoded from the instruction register
//   ra1, ra2     RegFile read addresses decoded from the instruction register
//   wa           RegFile write address decoded from the instruction register
//   we           RegFile write enable
//
// Modports:
//   master  the sequencer side (drives pc and the decoded controls)
//   slave   the memory/datapath side (drives instr and instr_valid)
// ---------------------------------------------------------------------------
interface seq_control_unit_if #(
    parameter int OP_W = 3,
    parameter int RA_W = 2,
    parameter int PC_W = 8
);
    logic [OP_W+3*RA_W-1:0] instr;
    logic                   instr_valid;
    logic [PC_W-1:0]        pc;
    logic [OP_W-1:0]        opcode;
    logic [RA_W-1:0]        ra1;
    logic [RA_W-1:0]        ra2;
    logic [RA_W-1:0]        wa;
    logic                   we;

    modport master (
        input  instr, instr_valid,
        output pc, opcode, ra1, ra2, wa, we
    );

    modport slave (
        output instr, instr_valid,
        input  pc, opcode, ra1, ra2, wa, we
    );
endinterface

// File: rtl/seq_control_unit.sv
// ---------------------------------------------------------------------------
// seq_control_unit
// Multi-cycle control FSM for the 8-bit ALU/RegFile CPU. Each instruction
// takes FETCH -> EXECUTE -> WRITEBACK -> NEXT (FETCH may stall on
// instr_valid). Supports start/restart, HALT and JMP opcodes, and counts
// retired instructions.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset    synchronous active-high reset
//   start    one-cycle pulse, begins execution at pc=0 from IDLE or DONE
//   bus      seq_control_unit_if.master: instr/instr_valid in,
//            pc/opcode/ra1/ra2/wa/we out
//   busy     high in FETCH, EXECUTE, WRITEBACK and NEXT
//   done     high in DONE
//   retired  instructions completed since the last start (saturating)
// ---------------------------------------------------------------------------
module seq_control_unit #(
    parameter int              OP_W    = 3,
    parameter int              RA_W    = 2,
    parameter int              PC_W    = 8,
    parameter int              LAST_PC = 2**PC_W - 1,
    parameter logic [OP_W-1:0] HALT_OP = OP_W'(3'b111),
    parameter logic [OP_W-1:0] JMP_OP  = OP_W'(3'b110),
    parameter int              CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    seq_control_unit_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     retired
);

    localparam int IR_W  = OP_W + 3*RA_W;
    localparam int TGT_W = 3*RA_W;
    localparam logic [PC_W-1:0] LAST_PC_V = PC_W'(LAST_PC);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXECUTE,
        WRITEBACK,
        NEXT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [OP_W-1:0]   ir_opcode;
    logic              ir_is_halt;
    logic              ir_is_jmp;
    logic [PC_W-1:0]   jmp_target;

    // Decode always comes from the registered IR so the datapath sees stable
    // fields for the whole instruction, even while instr changes in FETCH.
    assign ir_opcode  = ir_q[IR_W-1 -: OP_W];
    assign ir_is_halt = (ir_opcode == HALT_OP);
    assign ir_is_jmp  = (ir_opcode == JMP_OP);

    // The jump target is the concatenated {ra1, ra2, wa} field, resized to
    // the pc width (zero-extended when narrower, truncated when wider).
    assign jmp_target = PC_W'(ir_q[TGT_W-1:0]);

    assign bus.opcode = ir_opcode;
    assign bus.ra1    = ir_q[3*RA_W-1 -: RA_W];
    assign bus.ra2    = ir_q[2*RA_W-1 -: RA_W];
    assign bus.wa     = ir_q[RA_W-1:0];
    assign bus.pc     = pc_q;
    assign retired    = retired_q;

    // State register: synchronous reset wins over everything, including a
    // start pulse arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and output logic. Everything holds by default; each state
    // only overrides what it changes.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        bus.we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = FETCH;
                end
            end

            FETCH: begin
                busy = 1'b1;
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = EXECUTE;
                end
            end

            EXECUTE: begin
                busy    = 1'b1;
                state_d = WRITEBACK;
            end

            WRITEBACK: begin
                busy    = 1'b1;
                // Control-flow opcodes produce no ALU result to store.
                bus.we  = !(ir_is_halt || ir_is_jmp);
                state_d = NEXT;
            end

            NEXT: begin
                busy = 1'b1;
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + 1'b1;
                end
                // HALT beats JMP beats end-of-program; a JMP at LAST_PC still
                // jumps rather than finishing.
                if (ir_is_halt) begin
                    state_d = DONE;
                end else if (ir_is_jmp) begin
                    pc_d    = jmp_target;
                    state_d = FETCH;
                end else if (pc_q == LAST_PC_V) begin
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_control_unit
// Drives seq_control_unit from a program array and compares every cycle
// against an instruction-level reference model, plus directed scenarios
// with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_seq_control_unit;

    localparam int OP_W    = 3;
    localparam int RA_W    = 2;
    localparam int PC_W    = 8;
    localparam int LAST_PC = 3;
    localparam int CNT_W   = 16;
    localparam int IR_W    = OP_W + 3*RA_W;

    logic             clk;
    logic             reset;
    logic             start;
    logic             instr_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] retired;

    logic [IR_W-1:0]  prog [0:255];

    int assert_count;
    int fail_count;
    bit chk_en;

    // Model of the program as seen at the instruction level: whether a
    // program is running or finished, the current pc, the instruction
    // being worked on, how many cycles have elapsed since it was accepted
    // (0 means still waiting for it), and the retired count.
    bit              m_running;
    bit              m_finished;
    int              m_elapsed;
    logic [PC_W-1:0] m_pc;
    logic [IR_W-1:0] m_ir;
    logic [CNT_W-1:0] m_retired;

    int cyc;
    int we_count;
    int we_cycles [$];

    seq_control_unit_if #(.OP_W(OP_W), .RA_W(RA_W), .PC_W(PC_W)) bus ();

    seq_control_unit #(
        .OP_W    (OP_W),
        .RA_W    (RA_W),
        .PC_W    (PC_W),
        .LAST_PC (LAST_PC),
        .HALT_OP (3'b111),
        .JMP_OP  (3'b110),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .retired (retired)
    );

    // Instruction memory: the word at whatever address the DUT presents.
    assign bus.instr       = prog[bus.pc];
    assign bus.instr_valid = instr_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sets the inputs for the next rising edge, then returns just after it.
    task automatic applyStimulus(input logic r, input logic s, input logic v);
        reset       = r;
        start       = s;
        instr_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Keeps instr_valid high until the program finishes or the bound runs out.
    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("wait_done", {31'b0, done}, 32'd1);
    endtask

    // Advances until the model reaches a given pc and elapsed count.
    task automatic waitModel(input logic [PC_W-1:0] pc, input int elapsed, input int limit);
        int n;
        n = 0;
        while (!(m_running && m_pc == pc && m_elapsed == elapsed) && n < limit) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("wait_model_point", {31'b0, (m_running && m_pc == pc && m_elapsed == elapsed)}, 32'd1);
    endtask

    function automatic void clearProg();
        for (int i = 0; i < 256; i++) prog[i] = '0;
    endfunction

    // Reference model: each accepted instruction spends three more cycles
    // before retiring; retiring decides what happens to pc and whether the
    // program finishes.
    always @(posedge clk) begin
        if (reset) begin
            m_running  <= 1'b0;
            m_finished <= 1'b0;
            m_elapsed  <= 0;
            m_pc       <= '0;
            m_ir       <= '0;
            m_retired  <= '0;
        end else if (!m_running) begin
            if (start) begin
                m_running  <= 1'b1;
                m_finished <= 1'b0;
                m_elapsed  <= 0;
                m_pc       <= '0;
                m_retired  <= '0;
            end
        end else if (m_elapsed == 0) begin
            if (instr_valid) begin
                m_ir      <= prog[m_pc];
                m_elapsed <= 1;
            end
        end else if (m_elapsed < 3) begin
            m_elapsed <= m_elapsed + 1;
        end else begin
            m_elapsed <= 0;
            m_retired <= (m_retired == 16'hFFFF) ? m_retired : m_retired + 16'd1;
            if (m_ir[8:6] == 3'b111) begin
                m_running  <= 1'b0;
                m_finished <= 1'b1;
            end else if (m_ir[8:6] == 3'b110) begin
                m_pc <= {2'b00, m_ir[5:0]};
            end else if (m_pc == LAST_PC) begin
                m_running  <= 1'b0;
                m_finished <= 1'b1;
            end else begin
                m_pc <= m_pc + 8'd1;
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge so the
    // outputs have settled. Also tracks we pulses relative to the last start
    // (the cycle in which start is high counts as cycle 1).
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("pc",      {24'b0, bus.pc},     {24'b0, m_pc});
            checkOutput("opcode",  {29'b0, bus.opcode}, {29'b0, m_ir[8:6]});
            checkOutput("ra1",     {30'b0, bus.ra1},    {30'b0, m_ir[5:4]});
            checkOutput("ra2",     {30'b0, bus.ra2},    {30'b0, m_ir[3:2]});
            checkOutput("wa",      {30'b0, bus.wa},     {30'b0, m_ir[1:0]});
            checkOutput("we",      {31'b0, bus.we},
                        {31'b0, (m_running && m_elapsed == 2 && m_ir[8:7] != 2'b11)});
            checkOutput("busy",    {31'b0, busy},       {31'b0, m_running});
            checkOutput("done",    {31'b0, done},       {31'b0, m_finished});
            checkOutput("retired", {16'b0, retired},    {16'b0, m_retired});
        end
        cyc = start ? 1 : cyc + 1;
        if (bus.we === 1'b1) begin
            we_count++;
            we_cycles.push_back(cyc);
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        assert_count = 0;
        fail_count   = 0;
        chk_en       = 1'b0;
        cyc          = 0;
        we_count     = 0;
        clearProg();
        reset       = 1'b1;
        start       = 1'b0;
        instr_valid = 1'b0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_pc",      {24'b0, bus.pc},     32'd0);
        checkOutput("rst_busy",    {31'b0, busy},       32'd0);
        checkOutput("rst_done",    {31'b0, done},       32'd0);
        checkOutput("rst_opcode",  {29'b0, bus.opcode}, 32'd0);
        checkOutput("rst_retired", {16'b0, retired},    32'd0);

        // Straight four-instruction program ending at LAST_PC.
        $display("[TB] straight program");
        prog[0] = 9'h0A3; prog[1] = 9'h0C6; prog[2] = 9'h109; prog[3] = 9'h14C;
        we_count = 0;
        we_cycles.delete();
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitDone(100);
        checkOutput("straight_pc",      {24'b0, bus.pc},  32'd3);
        checkOutput("straight_retired", {16'b0, retired}, 32'd4);
        checkOutput("straight_we_count", we_count,        32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("straight_we_cycle",
                        (i < we_cycles.size()) ? we_cycles[i] : -1, (i + 1) * 4);
        end

        // Five-cycle stall while fetching pc=1.
        $display("[TB] fetch stall");
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitModel(8'd1, 0, 50);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("stall_pc",     {24'b0, bus.pc},     32'd1);
            checkOutput("stall_busy",   {31'b0, busy},       32'd1);
            checkOutput("stall_we",     {31'b0, bus.we},     32'd0);
            checkOutput("stall_opcode", {29'b0, bus.opcode}, 32'd2);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stall_after_pc",      {24'b0, bus.pc},  32'd2);
        checkOutput("stall_after_retired", {16'b0, retired}, 32'd2);
        waitDone(100);

        // HALT at pc=2.
        $display("[TB] halt");
        prog[2] = 9'h1C0;
        we_count = 0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitDone(100);
        checkOutput("halt_pc",       {24'b0, bus.pc},  32'd2);
        checkOutput("halt_retired",  {16'b0, retired}, 32'd3);
        checkOutput("halt_we_count", we_count,         32'd2);

        // JMP to 4, JMP 0x1B5 to 0x35, HALT there.
        $display("[TB] jump");
        clearProg();
        prog[0] = 9'h184; prog[4] = 9'h1B5; prog[8'h35] = 9'h1C0;
        we_count = 0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitModel(8'h04, 3, 50);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("jmp_target_pc", {24'b0, bus.pc},  32'h35);
        checkOutput("jmp_retired",   {16'b0, retired}, 32'd2);
        waitDone(100);
        checkOutput("jmp_final_pc",  {24'b0, bus.pc},  32'h35);
        checkOutput("jmp_we_count",  we_count,         32'd0);

        // Reset during WRITEBACK of pc=5, with a simultaneous start.
        $display("[TB] mid-run reset");
        clearProg();
        prog[0] = 9'h185; prog[5] = 9'h0A3;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitModel(8'h05, 2, 50);
        checkOutput("midrst_we_before", {31'b0, bus.we}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("midrst_pc",      {24'b0, bus.pc},  32'd0);
        checkOutput("midrst_we",      {31'b0, bus.we},  32'd0);
        checkOutput("midrst_busy",    {31'b0, busy},    32'd0);
        checkOutput("midrst_retired", {16'b0, retired}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midrst_idle_busy", {31'b0, busy}, 32'd0);

        // Restart from DONE, then a start pulse while busy.
        $display("[TB] restart");
        clearProg();
        prog[0] = 9'h0A3; prog[1] = 9'h0C6; prog[2] = 9'h109; prog[3] = 9'h14C;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitDone(100);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("restart_pc",      {24'b0, bus.pc},  32'd0);
        checkOutput("restart_retired", {16'b0, retired}, 32'd0);
        checkOutput("restart_busy",    {31'b0, busy},    32'd1);
        checkOutput("restart_done",    {31'b0, done},    32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("busy_start_pc",   {24'b0, bus.pc},  32'd1);
        waitDone(100);
        checkOutput("restart_final_retired", {16'b0, retired}, 32'd4);

        // Random programs, random valid gaps, random starts and rare resets.
        $display("[TB] random run");
        for (int i = 0; i < 256; i++) prog[i] = 9'($urandom_range(0, 511));
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
Parametrised multi-cycle control FSM for the 8-bit ALU/RegFile CPU.
- Fetches instructions from instruction memory through a valid handshake and latches each one into an instruction register (IR).
- Decodes the IR into ALU opcode and RegFile addresses, drives RegFile write enable, and manages the PC.
- Adds three capabilities to the basic FETCH/EXECUTE/WRITEBACK/NEXT sequencer: start/restart control, HALT and JMP opcodes, and a retired-instruction counter.
- Sits between instruction memory and the ALU/RegFile datapath.

Parameters:
OP_W, 3, opcode field width
RA_W, 2, register address field width (RegFile depth 2**RA_W)
PC_W, 8, program counter width
LAST_PC, 2**PC_W-1, address of the final instruction; sequential execution stops after it
HALT_OP, 3'b111 (OP_W bits), opcode that ends the program
JMP_OP, 3'b110 (OP_W bits), opcode for an unconditional jump
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins execution from pc=0 (honoured only in IDLE or DONE)
instr  in  OP_W+3*RA_W  instruction {opcode, ra1, ra2, wa}, MSB first
instr_valid  in  1  instr is valid for the current pc
opcode  out  OP_W  ALU opcode, taken from IR
ra1  out  RA_W  read address 1, taken from IR
ra2  out  RA_W  read address 2, taken from IR
wa  out  RA_W  write address, taken from IR
we  out  1  RegFile write enable
pc  out  PC_W  program counter to instruction memory
busy  out  1  high in FETCH, EXECUTE, WRITEBACK and NEXT
done  out  1  high in DONE
retired  out  CNT_W  number of instructions completed since the last start

Behaviour:
- Reset (synchronous, priority over all other inputs, in any state including mid-instruction):
  - state=IDLE; pc=0; IR=0; retired=0.
  - All outputs 0: we, done, busy are 0, and opcode/ra1/ra2/wa are 0 because IR=0.
- Decode: opcode/ra1/ra2/wa are driven combinationally from the registered IR in every state. They never come directly from instr.
- IDLE:
  - On start: pc<=0, retired<=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - If instr_valid: IR<=instr, go to EXECUTE.
  - Otherwise stall in FETCH, holding pc and IR. The stall length is unbounded.
- EXECUTE: unconditionally go to WRITEBACK. The ALU operates on the IR fields.
- WRITEBACK:
  - we=1 for exactly this one cycle, unless IR opcode is HALT_OP or JMP_OP, in which case we=0.
  - Unconditionally go to NEXT.
- NEXT (retired<=retired+1, saturating at 2**CNT_W-1; transitions checked in this priority order):
  - IR opcode==HALT_OP: go to DONE; pc is held.
  - IR opcode==JMP_OP: pc<={ra1,ra2,wa}, zero-extended or truncated to PC_W; go to FETCH. This applies even when pc==LAST_PC.
  - pc==LAST_PC: go to DONE; pc is held at LAST_PC, with no wrap to 0.
  - Otherwise: pc<=pc+1, go to FETCH.
- DONE:
  - done=1, we=0, busy=0. outputs hold the last IR value.
  - On start: pc<=0, retired<=0, go to FETCH (restart).
- start is ignored while busy=1.
- Latency: 4 cycles per instruction when instr_valid is high in FETCH; 4+N cycles with N stall cycles.
- Outputs from a 1-cycle start pulse: we is asserted exactly once per ALU instruction.

Test Plan:
- Straight program: reset, start, instr_valid=1, LAST_PC=3, instrs 0x0A3,0x0C6,0x109,0x14C -> we pulses in cycles 4,8,12,16 after start; pc steps 0,1,2,3; done=1 after the 4th NEXT with pc=3, retired=4.
- Stall: hold instr_valid=0 for 5 cycles in FETCH of pc=1 -> pc and IR unchanged, busy=1, we=0; the instruction then completes in 4 further cycles after valid rises.
- HALT at pc=2 (instr opcode 3'b111) -> we never high for it; done=1; pc stays 2; retired=3.
- JMP 0x1B5 (opcode 110, target 6'b110101) at pc=4 -> we=0; next FETCH at pc=0x35; retired increments by 1.
- Mid-run reset in WRITEBACK of pc=5 -> next cycle state IDLE, pc=0, we=0, busy=0, retired=0; a start pulse in the same cycle as reset is ignored.
- Restart from DONE: start pulse -> pc=0, retired=0, busy=1; a start pulse while busy has no effect on pc.
